// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Iteration counter must be able to hold the value WIDTH.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_array_multiplier_twos_magnitude.sv
// Combinational conditional two's-complement negate: abs() for operands,
// sign restoration for the product.
module twos_magnitude #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    if (enable) begin
      result = ~value + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or
// two's-complement, with a start/busy/done handshake and WIDTH-cycle latency.
module seq_array_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = count_width(WIDTH);

  state_t              state;
  logic [CW-1:0]       count;
  logic [2*WIDTH:0]    acc;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    mplier;
  logic                sign;

  logic                a_neg;
  logic                b_neg;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;
  logic [WIDTH:0]      upper_sum;
  logic [2*WIDTH:0]    acc_shift;
  logic [2*WIDTH-1:0]  prod_final;

  assign a_neg = signed_mode & a[WIDTH-1];
  assign b_neg = signed_mode & b[WIDTH-1];

  twos_magnitude #(.WIDTH(WIDTH)) u_a_mag (
    .value  (a),
    .enable (a_neg),
    .result (a_mag)
  );

  twos_magnitude #(.WIDTH(WIDTH)) u_b_mag (
    .value  (b),
    .enable (b_neg),
    .result (b_mag)
  );

  // Magnitudes are below 2^WIDTH, so the upper WIDTH+1 bits never overflow.
  always_comb begin
    upper_sum = acc[2*WIDTH:WIDTH];
    if (mplier[0]) begin
      upper_sum = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
    end
    acc_shift = {1'b0, upper_sum, acc[WIDTH-1:1]};
  end

  twos_magnitude #(.WIDTH(2*WIDTH)) u_result (
    .value  (acc_shift[2*WIDTH-1:0]),
    .enable (sign),
    .result (prod_final)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      sign    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            sign   <= a_neg ^ b_neg;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_shift;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            product <= prod_final;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
